servant_sleep_ctrl: RTL and testbench

- Power-management sequencer between the servant SoC and the board clock generator.
- Consumes the SoC's sleep/wakeup requests and the external interrupt line.
- Produces the clock-enable that gates the Wishbone/CPU clock in the clock generator, with a drain delay before gating and a resume delay before ungating.
- Also provides a saturating count of gated cycles for firmware power profiling.

---
 rtl/servant_sleep_ctrl_if.sv | 30 +++
 rtl/servant_sleep_ctrl.sv | 121 ++++++++++++
 tb/tb_servant_sleep_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/servant_sleep_ctrl_if.sv
// ============================================================================
// servant_sleep_ctrl_if : request/status bundle between SoC, IRQ line and clock-gen
// Revision 1.0
// ============================================================================
`default_nettype none

interface servant_sleep_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             i_sleep_req;
   logic             i_wakeup_req;
   logic             i_ext_irq;
   logic             i_cnt_clr;
   logic             o_clk_en;
   logic             o_sleeping;
   logic             o_wake_irq;
   logic [CNT_W-1:0] o_sleep_cycles;

   modport slave (
      input  i_sleep_req, i_wakeup_req, i_ext_irq, i_cnt_clr,
      output o_clk_en, o_sleeping, o_wake_irq, o_sleep_cycles
   );

   modport master (
      output i_sleep_req, i_wakeup_req, i_ext_irq, i_cnt_clr,
      input  o_clk_en, o_sleeping, o_wake_irq, o_sleep_cycles
   );
endinterface

`default_nettype wire

// File: rtl/servant_sleep_ctrl.sv
// ============================================================================
// servant_sleep_ctrl : sleep/wake sequencer driving the gated Wishbone clock enable
// Revision 1.0
// ============================================================================
`default_nettype none

module servant_sleep_ctrl #(
   parameter int DRAIN_CYCLES = 4,
   parameter int WAKE_CYCLES  = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_W        = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   servant_sleep_ctrl_if.slave  bus
);
   localparam int CNT_MAX = (DRAIN_CYCLES > WAKE_CYCLES) ? DRAIN_CYCLES : WAKE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0]    DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
   localparam logic [CW-1:0]    WAKE_LOAD  = CW'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CYC_SAT    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } state_t;

   state_t                 state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic                   cause, cause_nx;
   logic                   wake_irq_nx;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   irq_s, wake_src, sleep_rise;
   logic                   clk_en, sleeping, wake_irq;
   logic [CNT_W-1:0]       cycles;

   assign irq_s      = sync[SYNC_STAGES-1];
   assign wake_src   = bus.i_wakeup_req | irq_s;
   assign sleep_rise = bus.i_sleep_req & ~prev;

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      cause_nx    = cause;
      wake_irq_nx = 1'b0;
      case (state)
         ST_RUN: begin
            if (sleep_rise && !wake_src) begin
               state_nx = ST_DRAIN;
               cnt_nx   = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (wake_src) begin
               state_nx = ST_RUN;
            end else if (cnt == '0) begin
               state_nx = ST_SLEEP;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         ST_SLEEP: begin
            if (wake_src) begin
               state_nx = ST_WAKE;
               cnt_nx   = WAKE_LOAD;
               cause_nx = irq_s;
            end
         end
         ST_WAKE: begin
            if (cnt == '0) begin
               state_nx    = ST_RUN;
               wake_irq_nx = cause;
               cause_nx    = 1'b0;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= ST_RUN;
         cnt      <= '0;
         cause    <= 1'b0;
         sync     <= '0;
         // Track the request through reset so a level already high at release is not an edge.
         prev     <= bus.i_sleep_req;
         clk_en   <= 1'b1;
         sleeping <= 1'b0;
         wake_irq <= 1'b0;
         cycles   <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         cause    <= cause_nx;
         sync     <= {sync[SYNC_STAGES-2:0], bus.i_ext_irq};
         prev     <= bus.i_sleep_req;
         clk_en   <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
         sleeping <= (state_nx == ST_SLEEP) || (state_nx == ST_WAKE);
         wake_irq <= wake_irq_nx;
         if (bus.i_cnt_clr) begin
            cycles <= '0;
         end else if (((state == ST_SLEEP) || (state == ST_WAKE)) && (cycles != CYC_SAT)) begin
            cycles <= cycles + CNT_W'(1);
         end
      end
   end

   assign bus.o_clk_en       = clk_en;
   assign bus.o_sleeping     = sleeping;
   assign bus.o_wake_irq     = wake_irq;
   assign bus.o_sleep_cycles = cycles;

endmodule

`default_nettype wire

// File: tb/tb_servant_sleep_ctrl.sv
// ============================================================================
// tb_servant_sleep_ctrl : directed + random bench against a deadline-based model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_servant_sleep_ctrl;
   localparam int DRAIN = 4;
   localparam int WAKE  = 8;
   localparam int SYNC  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sleep_req = 1'b0, wakeup_req = 1'b0, ext_irq = 1'b0, cnt_clr = 1'b0;

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   servant_sleep_ctrl_if #(.CNT_W(32)) bus0 ();
   servant_sleep_ctrl_if #(.CNT_W(4))  bus1 ();

   assign bus0.i_sleep_req  = sleep_req;
   assign bus0.i_wakeup_req = wakeup_req;
   assign bus0.i_ext_irq    = ext_irq;
   assign bus0.i_cnt_clr    = cnt_clr;
   assign bus1.i_sleep_req  = sleep_req;
   assign bus1.i_wakeup_req = wakeup_req;
   assign bus1.i_ext_irq    = ext_irq;
   assign bus1.i_cnt_clr    = cnt_clr;

   servant_sleep_ctrl #(.DRAIN_CYCLES(DRAIN), .WAKE_CYCLES(WAKE), .SYNC_STAGES(SYNC), .CNT_W(32))
      dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
   servant_sleep_ctrl #(.DRAIN_CYCLES(DRAIN), .WAKE_CYCLES(WAKE), .SYNC_STAGES(SYNC), .CNT_W(4))
      dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phases with absolute deadline edges, irq delay as a sample queue.
   localparam int M_RUN = 0, M_DRAIN = 1, M_SLEEP = 2, M_WAKE = 3;
   int          edge_no = 0;
   int          m_mode = M_RUN;
   int          m_deadline = 0;
   bit          m_valid = 0;
   logic        m_prev = 1'b0, m_cause = 1'b0, m_pulse = 1'b0;
   logic [31:0] m_c32 = '0;
   logic [3:0]  m_c4 = '0;
   logic        irq_q[$];

   always @(posedge clk) begin
      logic irq_s, wake, rise, gated;
      edge_no++;
      if (!rst_n) begin
         m_valid = 1;
         m_mode  = M_RUN;
         m_prev  = sleep_req;
         m_cause = 1'b0;
         m_pulse = 1'b0;
         m_c32   = '0;
         m_c4    = '0;
         irq_q.delete();
         for (int i = 0; i < SYNC; i++) irq_q.push_back(1'b0);
      end else if (m_valid) begin
         irq_s = irq_q.pop_front();
         irq_q.push_back(ext_irq);
         wake   = wakeup_req | irq_s;
         rise   = sleep_req & ~m_prev;
         m_prev = sleep_req;
         gated  = (m_mode == M_SLEEP) || (m_mode == M_WAKE);
         if (cnt_clr) begin
            m_c32 = '0;
            m_c4  = '0;
         end else if (gated) begin
            if (m_c32 != 32'hFFFF_FFFF) m_c32 = m_c32 + 1;
            if (m_c4 != 4'hF) m_c4 = m_c4 + 1;
         end
         m_pulse = 1'b0;
         case (m_mode)
            M_RUN: if (rise && !wake) begin
               m_mode = M_DRAIN;
               m_deadline = edge_no + DRAIN;
            end
            M_DRAIN: begin
               if (wake) m_mode = M_RUN;
               else if (edge_no == m_deadline) m_mode = M_SLEEP;
            end
            M_SLEEP: if (wake) begin
               m_mode = M_WAKE;
               m_deadline = edge_no + WAKE;
               m_cause = irq_s;
            end
            default: if (edge_no == m_deadline) begin
               m_mode  = M_RUN;
               m_pulse = m_cause;
               m_cause = 1'b0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      logic exp_en;
      if (m_valid) begin
         exp_en = (m_mode == M_RUN) || (m_mode == M_DRAIN);
         check("clk_en",        bus0.o_clk_en,       exp_en);
         check("sleeping",      bus0.o_sleeping,     !exp_en);
         check("wake_irq",      bus0.o_wake_irq,     m_pulse);
         check("sleep_cycles",  bus0.o_sleep_cycles, m_c32);
         check("clk_en_w4",     bus1.o_clk_en,       exp_en);
         check("sleep_cycles4", bus1.o_sleep_cycles, m_c4);
         if (bus0.o_wake_irq) pulses++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int c_before;
      // Reset with sleep request held high.
      rst_n = 1'b0; sleep_req = 1'b1;
      tick(3);
      check("rst_clk_en", bus0.o_clk_en, 1);
      check("rst_sleeping", bus0.o_sleeping, 0);
      check("rst_cycles", bus0.o_sleep_cycles, 0);
      rst_n = 1'b1;
      tick(8);
      check("held_req_no_sleep", bus0.o_clk_en, 1);
      sleep_req = 1'b0;
      tick(2);

      // Full sleep/wake cycle.
      sleep_req = 1'b1;
      tick(4);
      check("drain_still_on", bus0.o_clk_en, 1);
      tick(1);
      check("gated_after_drain", bus0.o_clk_en, 0);
      tick(15);
      wakeup_req = 1'b1;
      tick(1);
      wakeup_req = 1'b0; sleep_req = 1'b0;
      tick(7);
      check("wake_still_off", bus0.o_clk_en, 0);
      tick(1);
      check("wake_on", bus0.o_clk_en, 1);
      check("full_cycles", bus0.o_sleep_cycles, 24);
      check("full_cycles_w4_sat", bus1.o_sleep_cycles, 15);
      check("full_no_irq", pulses, 0);

      // Drain abort.
      c_before = int'(bus0.o_sleep_cycles);
      sleep_req = 1'b1;
      tick(2);
      wakeup_req = 1'b1;
      tick(1);
      wakeup_req = 1'b0;
      tick(8);
      check("abort_clk_en", bus0.o_clk_en, 1);
      check("abort_cycles", bus0.o_sleep_cycles, c_before);
      sleep_req = 1'b0;
      tick(2);

      // IRQ wake.
      pulses = 0;
      sleep_req = 1'b1;
      tick(7);
      #2 ext_irq = 1'b1;
      tick(10);
      check("irq_wake_still_off", bus0.o_clk_en, 0);
      tick(1);
      check("irq_wake_on", bus0.o_clk_en, 1);
      check("irq_pulse", bus0.o_wake_irq, 1);
      ext_irq = 1'b0;
      tick(1);
      check("irq_pulse_single", bus0.o_wake_irq, 0);
      tick(3);
      check("irq_pulse_count", pulses, 1);
      sleep_req = 1'b0;
      tick(2);

      // Pending IRQ blocks sleep, request is not retried.
      ext_irq = 1'b1;
      tick(4);
      sleep_req = 1'b1;
      tick(3);
      ext_irq = 1'b0;
      tick(12);
      check("pending_irq_clk_en", bus0.o_clk_en, 1);
      sleep_req = 1'b0;
      tick(2);

      // Saturation and clear on the 4-bit counter.
      sleep_req = 1'b1;
      tick(26);
      check("sat_w4", bus1.o_sleep_cycles, 15);
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      check("clr_w4", bus1.o_sleep_cycles, 0);
      check("clr_w32", bus0.o_sleep_cycles, 0);
      tick(1);
      check("clr_then_1", bus1.o_sleep_cycles, 1);
      tick(1);
      check("clr_then_2", bus1.o_sleep_cycles, 2);
      wakeup_req = 1'b1;
      tick(1);
      wakeup_req = 1'b0; sleep_req = 1'b0;
      tick(10);

      // Randomized traffic, including mid-operation resets.
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 5) == 0) sleep_req = ~sleep_req;
         wakeup_req = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 24) == 0) ext_irq = ~ext_irq;
         cnt_clr = ($urandom_range(0, 59) == 0);
         rst_n = ($urandom_range(0, 599) != 0);
         tick(1);
      end
      rst_n = 1'b1;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
